// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm FSM: armed, ringing, snooze and dismiss-game phases for the mm:ss clock
module alarm_sequencer #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int GAME_TIMEOUT_S = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic [15:0] current_time,
    input  logic [15:0] alarm_time,
    input  logic        alarm_enable,
    input  logic        snooze_btn,
    input  logic        dismiss_btn,
    input  logic        game_pass,
    input  logic        game_fail,
    output logic [2:0]  alarm_state,
    output logic        snooze_active,
    output logic        alarm_missed,
    output logic [15:0] game_countdown
);

    typedef enum logic [2:0] {
        S_OFF,
        S_ARMED,
        S_SNOOZE,
        S_RINGING,
        S_GAME
    } state_t;

    localparam logic [9:0] RING_LIM    = 10'(RING_TIMEOUT_S);
    localparam logic [9:0] SNOOZE_INIT = 10'(SNOOZE_S);
    localparam logic [7:0] GAME_BCD    = {4'(GAME_TIMEOUT_S / 10), 4'(GAME_TIMEOUT_S % 10)};

    state_t     r_state;
    logic       r_match_q;
    logic [9:0] r_ring_cnt;
    logic [9:0] r_snooze_cnt;
    logic [7:0] r_game;
    logic [2:0] r_alarm_state;
    logic       r_snooze_active;
    logic       r_missed;

    logic       w_match;
    logic       w_fire;
    logic [7:0] w_game_dec;

    // Rising edge of the match only, so a held match rings once.
    assign w_match = (current_time == alarm_time);
    assign w_fire  = w_match & ~r_match_q;

    assign w_game_dec = (r_game[3:0] == 4'd0) ? {r_game[7:4] - 4'd1, 4'd9}
                                              : {r_game[7:4], r_game[3:0] - 4'd1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_OFF;
            r_match_q       <= 1'b0;
            r_ring_cnt      <= 10'd0;
            r_snooze_cnt    <= 10'd0;
            r_game          <= 8'h00;
            r_alarm_state   <= 3'b000;
            r_snooze_active <= 1'b0;
            r_missed        <= 1'b0;
        end else begin
            r_match_q <= w_match;
            if (!alarm_enable) begin
                r_state         <= S_OFF;
                r_alarm_state   <= 3'b000;
                r_snooze_active <= 1'b0;
                r_missed        <= 1'b0;
                r_game          <= 8'h00;
            end else begin
                case (r_state)
                    S_OFF: begin
                        r_state       <= S_ARMED;
                        r_alarm_state <= 3'b001;
                    end
                    S_ARMED: begin
                        if (w_fire) begin
                            r_state       <= S_RINGING;
                            r_alarm_state <= 3'b010;
                            r_ring_cnt    <= 10'd0;
                            r_missed      <= 1'b0;
                        end
                    end
                    S_RINGING: begin
                        if (dismiss_btn) begin
                            r_state       <= S_GAME;
                            r_alarm_state <= 3'b100;
                            r_game        <= GAME_BCD;
                        end else if (snooze_btn) begin
                            r_state         <= S_SNOOZE;
                            r_alarm_state   <= 3'b001;
                            r_snooze_active <= 1'b1;
                            r_snooze_cnt    <= SNOOZE_INIT;
                        end else if (tick_1hz) begin
                            if (r_ring_cnt + 10'd1 == RING_LIM) begin
                                r_state       <= S_ARMED;
                                r_alarm_state <= 3'b001;
                                r_missed      <= 1'b1;
                            end else begin
                                r_ring_cnt <= r_ring_cnt + 10'd1;
                            end
                        end
                    end
                    S_SNOOZE: begin
                        if (tick_1hz) begin
                            if (r_snooze_cnt == 10'd1) begin
                                r_state         <= S_RINGING;
                                r_alarm_state   <= 3'b010;
                                r_snooze_active <= 1'b0;
                                r_ring_cnt      <= 10'd0;
                                r_snooze_cnt    <= 10'd0;
                            end else begin
                                r_snooze_cnt <= r_snooze_cnt - 10'd1;
                            end
                        end
                    end
                    S_GAME: begin
                        if (game_pass) begin
                            r_state       <= S_ARMED;
                            r_alarm_state <= 3'b001;
                            r_game        <= 8'h00;
                        end else if (game_fail || (tick_1hz && r_game == 8'h01)) begin
                            r_state       <= S_RINGING;
                            r_alarm_state <= 3'b010;
                            r_ring_cnt    <= 10'd0;
                            r_game        <= 8'h00;
                        end else if (tick_1hz) begin
                            r_game <= w_game_dec;
                        end
                    end
                    default: begin
                        r_state       <= S_OFF;
                        r_alarm_state <= 3'b000;
                    end
                endcase
            end
        end
    end

    assign alarm_state    = r_alarm_state;
    assign snooze_active  = r_snooze_active;
    assign alarm_missed   = r_missed;
    assign game_countdown = {8'h00, r_game};

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Controls the alarm function of the mm:ss BCD clock. It watches the running time against the set alarm time and moves through armed, ringing, snooze and dismiss-game phases. It drives the 3-bit alarm_state code that the LED and anode/display logic decode. It also drives a BCD countdown for the 7-segment display during the dismiss game.

Parameters:
RING_TIMEOUT_S, 60, seconds RINGING lasts before auto-stop (1..1023)
SNOOZE_S, 300, snooze length in seconds (1..1023)
GAME_TIMEOUT_S, 30, dismiss-game time limit in seconds; must be 1..99 (BCD countdown)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick_1hz  in  1  one-cycle pulse per second, synchronous to clk
current_time  in  16  running time, BCD mm:ss {m1,m0,s1,s0}
alarm_time  in  16  alarm set point, same BCD format
alarm_enable  in  1  level; 0 forces OFF
snooze_btn  in  1  one-cycle pulse, debounced upstream
dismiss_btn  in  1  one-cycle pulse, debounced upstream
game_pass  in  1  one-cycle pulse from mini-game
game_fail  in  1  one-cycle pulse from mini-game
alarm_state  out  3  000 OFF, 001 ARMED/SNOOZE, 010 RINGING, 100 GAME
snooze_active  out  1  high only in SNOOZE
alarm_missed  out  1  sticky: ring timed out unanswered
game_countdown  out  16  BCD seconds remaining in GAME: {8'h00, s1, s0}; 0 elsewhere

Behaviour:
- Reset (async): state OFF, alarm_state=000, snooze_active=0, alarm_missed=0, game_countdown=0, ring/snooze counters=0, match_q=0.
- All outputs are registered and update on the same clk edge as the state register.
- Decode mapping: OFF→000, ARMED→001, SNOOZE→001, RINGING→010, GAME→100. No other codes are emitted.
- match = (current_time == alarm_time), registered each cycle into match_q. fire = match & ~match_q. A match held over many cycles fires once.
- Priority in every state: alarm_enable=0 → OFF next edge, ahead of all other events.
- OFF: alarm_enable=1 → ARMED. alarm_missed cleared on entry to OFF.
- ARMED:
  - fire → RINGING; ring counter := 0; alarm_missed := 0.
  - Re-arming while match is already true does not fire, because match_q is already 1.
- RINGING:
  - Event priority: dismiss_btn > snooze_btn > tick.
  - dismiss_btn → GAME; game_countdown := BCD(GAME_TIMEOUT_S).
  - snooze_btn → SNOOZE; snooze counter := SNOOZE_S.
  - tick: ring counter +1. When the incremented value = RING_TIMEOUT_S → ARMED, alarm_missed := 1.
- SNOOZE:
  - tick: snooze counter −1. On the tick that reaches 0 → RINGING, ring counter := 0.
  - snooze_btn and dismiss_btn are ignored; fire is ignored.
- GAME:
  - Event priority: game_pass > game_fail > tick.
  - game_pass → ARMED; game_countdown := 0.
  - game_fail → RINGING; ring counter := 0.
  - tick: BCD decrement of game_countdown (s0=0 → s0:=9 and s1−1). On the tick taking the count 01→00 → RINGING.
- A button pulse that coincides with tick is handled as the button event. The tick is not also applied.
- Counter widths: 10 bits, no wrap, because transitions occur before any terminal value can be passed.
- Reset mid-operation returns to OFF immediately, regardless of state.

Test Plan:
1. Fire once: alarm_enable=1, alarm_time=16'h0105; step current_time 0104→0105 and hold 5 cycles → alarm_state 010 one edge after the match, and exactly one entry to RINGING. Then re-arm with current_time still 0105 → stays 001.
2. Ring timeout: in RINGING issue 60 tick_1hz pulses → after the 60th tick, alarm_state=001 and alarm_missed=1. A subsequent fire clears alarm_missed.
3. Snooze (SNOOZE_S=5): snooze_btn in RINGING → alarm_state=001, snooze_active=1; 4 ticks → still SNOOZE; 5th tick → 010, snooze_active=0. dismiss_btn during SNOOZE has no effect.
4. Game pass: dismiss_btn in RINGING → alarm_state=100, game_countdown=16'h0030. 3 ticks → 16'h0027 (BCD borrow checked at 30→29). game_pass → 001, countdown 0.
5. Game fail, timeout, priority:
   - 30 ticks in GAME → 010.
   - game_fail → 010.
   - game_pass and game_fail in the same cycle → 001.
   - snooze_btn and dismiss_btn in the same cycle in RINGING → 100.
6. Kill paths:
   - alarm_enable=0 during RINGING → 000 next edge.
   - Async reset asserted mid-cycle during SNOOZE → 000 and snooze_active=0 without waiting for clk.
